lbp_stream_gen: RTL
===================

// Module: lbp_stream_gen
// PURPOSE
//  Parametrised Local Binary Pattern generator: reads an IMG_W x IMG_H grey image from external memory,
//  writes one 8-bit LBP code per pixel in raster order. Successor to the fixed 128x128 LBP block:
//  generic size/pixel width, sliding 3x3 window (3 reads per interior pixel), read stalls, optional uniform coding.
// PARAMETERS
//  IMG_W   128  image width in pixels, >=3
//  IMG_H   128  image height in pixels, >=3
//  PIX_W   8    grey pixel width in bits
//  ADDR_W  14   address width, >= clog2(IMG_W*IMG_H)
// PORTS
//  clk         in   1       clock, all flops on rising edge
//  reset       in   1       synchronous, active-high reset
//  gray_ready  in   1       image memory ready; reads issue only while high
//  gray_req    out  1       read request, qualifies gray_addr
//  gray_addr   out  ADDR_W  read address = row*IMG_W+col
//  gray_data   in   PIX_W   read data, valid the cycle after an accepted request
//  lbp_valid   out  1       one-cycle write strobe
//  lbp_addr    out  ADDR_W  write address, raster index of the pixel
//  lbp_data    out  8       LBP code
//  finish      out  1       high from the cycle after the last write; held until reset
// BEHAVIOUR
//  Reset: sync reset, active-high; all outputs 0 on the next edge, FSM->IDLE, row=col=0. Reset mid-frame
//   abandons the frame; no strobe or request in the cycle after reset is sampled.
//  Request accepted when gray_req&&gray_ready; data captured on the following edge. gray_ready low: hold
//   gray_addr/gray_req, no state progress (stall). Drop of gray_ready never loses or duplicates a read.
//  Row base kept as running sum (+IMG_W per row); no multiplier.
//  States: IDLE->(gray_ready) BORDER|FILL; BORDER: write 0 (row 0, row IMG_H-1, col 0, col IMG_W-1),
//   no reads, 1 cycle/pixel; FILL: 9 reads, first interior pixel of a row; SLIDE: shift window left,
//   3 reads of column col+1; CALC: form code, 1 cycle; WRITE: lbp_valid=1, 1 cycle; then advance col/row
//   -> BORDER|SLIDE|FILL|DONE. DONE: finish=1, idle until reset.
//  Code: bit set iff neighbour >= centre (unsigned PIX_W compare). Bit order: 0 (r-1,c-1), 1 (r-1,c),
//   2 (r-1,c+1), 3 (r,c-1), 4 (r,c+1), 5 (r+1,c-1), 6 (r+1,c), 7 (r+1,c+1).
//  Timing, gray_ready held high: FILL pixel 11 cycles, SLIDE pixel 5 cycles, border pixel 1 cycle.
//  Writes strictly in raster order, exactly IMG_W*IMG_H strobes per frame; lbp_addr/lbp_data stable only
//   while lbp_valid=1. finish rises one cycle after the strobe for index IMG_W*IMG_H-1.
//  Wrap: col IMG_W-1 -> 0 with row+1; row/col counters never wrap past IMG_H-1.
// CONFIGURATION
//  LBP_UNIFORM_EN defined: lbp_data = riu2 code: popcount(raw) if circular transitions <=2 (neighbour ring
//   order 0,1,2,4,7,6,5,3), else 9; range 0..9, bits [7:4]=0. Border pixels still 0. Timing unchanged.
//  Not defined: lbp_data = raw 8-bit code above.
// STRUCTURE
//  Package lbp_pkg: FSM state enum (IDLE,BORDER,FILL,SLIDE,CALC,WRITE,DONE), neighbour bit-index
//   constants, ring-order table, UNIFORM_NONUNI=9.
//  Sub-module lbp_code: combinational 8 comparators + optional riu2 mapping; FSM, address gen,
//   3x3 window regs in the top.
// TESTING
//  1 IMG_W=IMG_H=4, ramp image p=index -> 16 strobes; border 0; (1,1)=8'hF0, (1,2)=8'hF0; finish after 16th.
//  2 Constant image 8'h55, 128x128 -> interior codes 8'hFF, border 0, 16384 strobes, no gaps in lbp_addr.
//  3 Toggle gray_ready low 3 cycles every 7 -> output stream identical to test 2; gray_addr held during stall.
//  4 Assert reset mid-row 5 -> outputs 0 next cycle, restart writes from lbp_addr 0, correct full frame.
//  5 LBP_UNIFORM_EN, centre 100, neighbours {bits0-2 >=,rest <} -> 3; checkerboard ring -> 9.
//  6 Non-square IMG_W=5 IMG_H=3 -> 15 writes, only (1,1..3) interior, FILL at col1, SLIDE at cols 2,3.

Source files
------------

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared FSM states, neighbour/ring tables and riu2 constant for the LBP generator
package lbp_pkg;
  typedef enum logic [2:0] {IDLE, BORDER, FILL, SLIDE, CALC, WRITE, DONE} state_t;
  // window slot (row*3+col) feeding each code bit, bit 0 in the lowest nibble
  localparam logic [7:0][3:0] NB_IDX = {4'd8, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0};
  // code bits visited walking the neighbour ring: 0,1,2,4,7,6,5,3
  localparam logic [7:0][2:0] RING = {3'd3, 3'd5, 3'd6, 3'd7, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [7:0] UNIFORM_NONUNI = 8'd9;
endpackage

// File: rtl/lbp_stream_gen_if.sv
// lbp_stream_gen_if: image-read and code-write bus of the LBP generator
interface lbp_stream_gen_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W = 8
);
  logic gray_ready;
  logic gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0] gray_data;
  logic lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0] lbp_data;
  logic finish;
  modport master (
    input gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
  modport slave (
    output gray_ready, gray_data,
    input gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_code.sv
// lbp_code: 3x3 window to LBP code; LBP_UNIFORM_EN selects riu2 mapping instead of the raw code
module lbp_code
  import lbp_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [8:0][PIX_W-1:0] win,
  output logic [7:0]            code
);
  logic [7:0] raw;
  // one unsigned neighbour >= centre compare per code bit
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[i] = win[NB_IDX[i]] >= win[4];
  end
`ifdef LBP_UNIFORM_EN
  logic [3:0] ones, trans;
  // rotation-invariant uniform: popcount when the ring has at most two 0/1 transitions
  always_comb begin
    ones = '0;
    trans = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + 4'(raw[i]);
      trans = trans + 4'(raw[RING[i]] != raw[RING[(i + 1) % 8]]);
    end
    code = trans <= 4'd2 ? 8'(ones) : UNIFORM_NONUNI;
  end
`else
  assign code = raw;
`endif
endmodule

// File: rtl/lbp_stream_gen.sv
// lbp_stream_gen: streaming LBP generator, sliding 3x3 window over external memory (see LBP_UNIFORM_EN in lbp_code)
module lbp_stream_gen
  import lbp_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int ADDR_W = 14
) (
  input logic clk,
  input logic reset,
  lbp_stream_gen_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, nc;
  logic [RW-1:0] row_q, row_d, nr;
  logic [ADDR_W-1:0] base_q, base_d, nbase, idx_q, idx_d, gaddr_q, gaddr_d, laddr_q, laddr_d;
  logic [3:0] slot_q, slot_d, pslot_q, pslot_d;
  logic pend_q, pend_d, req_q, req_d, valid_q, valid_d, fin_q, fin_d;
  logic [7:0] ldata_q, ldata_d, code;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic last_col, nborder, fire;

  // code is formed from win_d so the read landing in CALC is already included
  lbp_code #(.PIX_W(PIX_W)) u_code (.win(win_d), .code(code));

  assign bus.gray_req = req_q;
  assign bus.gray_addr = gaddr_q;
  assign bus.lbp_valid = valid_q;
  assign bus.lbp_addr = laddr_q;
  assign bus.lbp_data = ldata_q;
  assign bus.finish = fin_q;

  // FSM next state, read sequencing, window capture and next registered outputs
  always_comb begin
    last_col = col_q == CW'(IMG_W - 1);
    nc = last_col ? '0 : col_q + 1'b1;
    nr = last_col ? row_q + 1'b1 : row_q;
    nbase = last_col ? base_q + W_A : base_q;
    nborder = nr == '0 || nr == RW'(IMG_H - 1) || nc == '0 || nc == CW'(IMG_W - 1);
    fire = req_q && bus.gray_ready;
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    base_d = base_q;
    idx_d = idx_q;
    gaddr_d = gaddr_q;
    laddr_d = laddr_q;
    ldata_d = ldata_q;
    slot_d = slot_q;
    req_d = req_q;
    valid_d = 1'b0;
    fin_d = fin_q;
    pend_d = fire;
    pslot_d = slot_q;
    win_d = win_q;
    if (pend_q) win_d[pslot_q] = bus.gray_data;
    unique case (state_q)
      IDLE: if (bus.gray_ready) begin
        state_d = BORDER;
        valid_d = 1'b1;
        laddr_d = '0;
        ldata_d = '0;
      end
      FILL, SLIDE: if (fire) begin
        if (slot_q == 4'd8) begin
          state_d = CALC;
          req_d = 1'b0;
        end else begin
          slot_d = slot_q + (state_q == SLIDE ? 4'd3 : 4'd1);
          gaddr_d = gaddr_q + (state_q == SLIDE ? W_A :
                    (slot_q == 4'd2 || slot_q == 4'd5) ? W_A - ADDR_W'(2) : ADDR_W'(1));
        end
      end
      CALC: begin
        state_d = WRITE;
        valid_d = 1'b1;
        laddr_d = idx_q;
        ldata_d = code;
      end
      BORDER, WRITE: if (last_col && row_q == RW'(IMG_H - 1)) begin
        state_d = DONE;
        fin_d = 1'b1;
      end else begin
        col_d = nc;
        row_d = nr;
        base_d = nbase;
        idx_d = idx_q + 1'b1;
        if (nborder) begin
          state_d = BORDER;
          valid_d = 1'b1;
          laddr_d = idx_q + 1'b1;
          ldata_d = '0;
        end else if (nc == CW'(1)) begin
          state_d = FILL;
          req_d = 1'b1;
          slot_d = 4'd0;
          gaddr_d = nbase - W_A + ADDR_W'(nc) - ADDR_W'(1);
        end else begin
          state_d = SLIDE;
          req_d = 1'b1;
          slot_d = 4'd2;
          gaddr_d = nbase - W_A + ADDR_W'(nc) + ADDR_W'(1);
          for (int r = 0; r < 3; r++) begin
            win_d[3*r] = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
          end
        end
      end
      default: ;
    endcase
  end

  // state and output registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      base_q <= '0;
      idx_q <= '0;
      gaddr_q <= '0;
      laddr_q <= '0;
      ldata_q <= '0;
      slot_q <= '0;
      pslot_q <= '0;
      pend_q <= 1'b0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      fin_q <= 1'b0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      base_q <= base_d;
      idx_q <= idx_d;
      gaddr_q <= gaddr_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
      slot_q <= slot_d;
      pslot_q <= pslot_d;
      pend_q <= pend_d;
      req_q <= req_d;
      valid_q <= valid_d;
      fin_q <= fin_d;
      win_q <= win_d;
    end
  end
endmodule
